// File: rtl/pattern_gen_param_if.sv
// Test-pattern bus: frame control into the generator and the sync/pixel stream it drives.
// The generator takes the master side; a sink or controller takes the slave side.
interface pattern_gen_param_if #(
    parameter int unsigned DW = 8
);
    logic          start;
    logic          cont;
    logic [1:0]    mode;
    logic [DW-1:0] level;
    logic          h_sync;
    logic          v_sync;
    logic          d_en;
    logic [DW-1:0] data;
    logic          busy;

    modport master (
        input  start, cont, mode, level,
        output h_sync, v_sync, d_en, data, busy
    );

    modport slave (
        output start, cont, mode, level,
        input  h_sync, v_sync, d_en, data, busy
    );
endinterface

// File: rtl/pattern_gen_param.sv
// Free-running video test-pattern source: a start edge launches whole frames of
// H_BLANK sync cycles plus H_ACTIVE pixels per line, optionally repeating.
module pattern_gen_param #(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter int unsigned H_BLANK   = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned RAMP_STEP = 7,
    parameter int unsigned RAMP_OFS  = 9,
    parameter int unsigned CHECK     = 64
) (
    input logic                 clock,
    input logic                 n_reset,
    pattern_gen_param_if.master bus
);
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned HW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
    localparam int unsigned SW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
    localparam int unsigned CB = $clog2(CHECK);

    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(H_BLANK - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(RAMP_STEP - 1);

    typedef enum logic [1:0] {StIdle, StHblank, StActive} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [XW-1:0] seg_q, seg_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] level_q, level_d;
    logic          s1_q, s2_q;
    logic          d_en_q, d_en_d;
    logic [DW-1:0] data_q, data_d;

    logic          start_pe;
    logic [31:0]   seg_ext;
    logic [31:0]   chk_ext;
    logic          in_win;
    logic [DW-1:0] ramp;
    logic [DW-1:0] pix;

    assign start_pe = s1_q & ~s2_q;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sub_d   = sub_q;
        seg_d   = seg_q;
        mode_d  = mode_q;
        level_d = level_q;
        case (state_q)
            StIdle: begin
                if (start_pe) begin
                    state_d = StHblank;
                    hcnt_d  = '0;
                    y_d     = '0;
                    mode_d  = bus.mode;
                    level_d = bus.level;
                end
            end
            StHblank: begin
                if (hcnt_q == HCNT_LAST) begin
                    state_d = StActive;
                    x_d     = '0;
                    sub_d   = '0;
                    seg_d   = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StActive: begin
                if (x_q == X_LAST) begin
                    state_d = StHblank;
                    hcnt_d  = '0;
                    if (y_q == Y_LAST) begin
                        y_d = '0;
                        // cont is sampled only on the last pixel of the frame
                        if (bus.cont) begin
                            mode_d  = bus.mode;
                            level_d = bus.level;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        seg_d = seg_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel is computed from next-state counters so d_en and data register together.
    always_comb begin
        seg_ext = 32'(seg_d);
        chk_ext = ((32'(x_d) ^ 32'(y_d)) >> CB) & 32'd1;
        in_win  = (seg_ext >= RAMP_OFS) && (seg_ext < RAMP_OFS + 2 ** DW);
        ramp    = in_win ? DW'(seg_ext - RAMP_OFS) : '0;
        pix     = '0;
        case (mode_d)
            2'd0:    pix = ramp;
            2'd1:    pix = (chk_ext != 32'd0) ? '1 : '0;
            2'd2:    pix = level_d;
            default: pix = in_win ? ~ramp : '0;
        endcase
        d_en_d = (state_d == StActive);
        data_d = d_en_d ? pix : '0;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= '0;
            seg_q   <= '0;
            mode_q  <= '0;
            level_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            d_en_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
            seg_q   <= seg_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            s1_q    <= bus.start;
            s2_q    <= s1_q;
            d_en_q  <= d_en_d;
            data_q  <= data_d;
        end
    end

    assign bus.h_sync = (state_q == StHblank);
    assign bus.v_sync = (state_q == StHblank) && (y_q == '0);
    assign bus.busy   = (state_q != StIdle);
    assign bus.d_en   = d_en_q;
    assign bus.data   = data_q;
endmodule

// File: tb/tb_pattern_gen_param.sv
// Bench for pattern_gen_param at reduced geometry: every cycle is compared against a
// frame-timeline model (cycle offset -> line/pixel -> pattern arithmetic).
module tb_pattern_gen_param;
    localparam int unsigned H_A   = 60;
    localparam int unsigned V_A   = 6;
    localparam int unsigned H_B   = 3;
    localparam int unsigned DW    = 4;
    localparam int unsigned RS    = 3;
    localparam int unsigned RO    = 2;
    localparam int unsigned CK    = 4;
    localparam int          L     = H_A + H_B;
    localparam int          FRAME = V_A * L;

    logic clock;
    logic n_reset;

    pattern_gen_param_if #(.DW(DW)) bus ();

    pattern_gen_param #(
        .H_ACTIVE (H_A),
        .V_ACTIVE (V_A),
        .H_BLANK  (H_B),
        .DW       (DW),
        .RAMP_STEP(RS),
        .RAMP_OFS (RO),
        .CHECK    (CK)
    ) dut (
        .clock  (clock),
        .n_reset(n_reset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position in the frame timeline plus the per-frame latched settings.
    bit            m_busy;
    int            m_t;
    int            m_frames;
    logic [1:0]    m_mode;
    logic [DW-1:0] m_level;
    bit            m_s1, m_s2;
    logic [DW-1:0] fbuf [V_A][H_A];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix_ref(input logic [1:0] md, input logic [DW-1:0] lv,
                                             input int x, input int y);
        int seg;
        int r;
        bit win;
        seg = x / RS;
        win = (seg >= RO) && (seg < RO + (1 << DW));
        r   = win ? seg - RO : 0;
        case (md)
            2'd0:    return DW'(r);
            2'd1:    return (((x / CK) + (y / CK)) % 2 == 1) ? {DW{1'b1}} : '0;
            2'd2:    return lv;
            default: return win ? DW'((1 << DW) - 1 - r) : '0;
        endcase
    endfunction

    task automatic compare();
        int line;
        int pos;
        bit hs;
        bit de;
        logic [DW-1:0] dv;
        line = m_t / L;
        pos  = m_t % L;
        hs   = m_busy && (pos < H_B);
        de   = m_busy && (pos >= H_B);
        dv   = de ? pix_ref(m_mode, m_level, pos - H_B, line) : '0;
        check("h_sync", 32'(bus.h_sync), 32'(hs));
        check("v_sync", 32'(bus.v_sync), 32'(hs && (line == 0)));
        check("d_en",   32'(bus.d_en),   32'(de));
        check("data",   32'(bus.data),   32'(dv));
        check("busy",   32'(bus.busy),   32'(m_busy));
        if (de) fbuf[line][pos - H_B] = bus.data;
    endtask

    task automatic step();
        bit pe;
        @(posedge clock);
        if (n_reset) begin
            pe   = m_s1 & ~m_s2;
            m_s2 = m_s1;
            m_s1 = bus.start;
            if (!m_busy) begin
                if (pe) begin
                    m_busy  = 1'b1;
                    m_t     = 0;
                    m_mode  = bus.mode;
                    m_level = bus.level;
                end
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_frames++;
                    if (bus.cont) begin
                        m_t     = 0;
                        m_mode  = bus.mode;
                        m_level = bus.level;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end
        end
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        #1;
        m_busy = 1'b0;
        m_t    = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        compare();
        step();
        step();
        n_reset = 1'b1;
    endtask

    task automatic clear_buf();
        for (int y = 0; y < V_A; y++)
            for (int x = 0; x < H_A; x++) fbuf[y][x] = 'x;
    endtask

    task automatic launch();
        clear_buf();
        bus.start = 1'b1;
        step();
        step();
        step();
        bus.start = 1'b0;
    endtask

    // Runs until the DUT drops busy; jitter perturbs mode/level/start early in each frame.
    task automatic run_until_idle(input bit jitter, input bit cont_jitter, input int budget);
        int n;
        int f0;
        n  = 0;
        f0 = m_frames;
        while (bus.busy && n < budget) begin
            if (jitter && m_t < FRAME / 2) begin
                if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom);
                if ($urandom_range(0, 7) == 0) bus.level = DW'($urandom);
                if ($urandom_range(0, 15) == 0) bus.start = ~bus.start;
            end else begin
                bus.start = 1'b0;
            end
            if (cont_jitter && $urandom_range(0, 31) == 0) bus.cont = ~bus.cont;
            if (m_frames >= f0 + 2) bus.cont = 1'b0;
            step();
            n++;
        end
        check("idle_reached", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        int bad;
        int vs_rises;
        int busy_cyc;
        int n;
        bit vs_prev;
        n_reset   = 1'b0;
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        bus.mode  = 2'd0;
        bus.level = '0;
        m_frames  = 0;
        m_mode    = '0;
        m_level   = '0;
        @(negedge clock);
        do_reset();
        repeat (3) step();

        // Ramp and inverted ramp: window edges at seg RO and RO+2^DW.
        bus.mode = 2'd0;
        launch();
        run_until_idle(1'b0, 1'b0, 2 * FRAME);
        check("ramp_x5",  32'(fbuf[0][5]),  32'd0);
        check("ramp_x6",  32'(fbuf[0][6]),  32'd0);
        check("ramp_x9",  32'(fbuf[0][9]),  32'd1);
        check("ramp_x53", 32'(fbuf[0][53]), 32'd15);
        check("ramp_x54", 32'(fbuf[0][54]), 32'd0);
        bus.mode = 2'd3;
        launch();
        run_until_idle(1'b0, 1'b0, 2 * FRAME);
        check("inv_x0",  32'(fbuf[0][0]),  32'd0);
        check("inv_x6",  32'(fbuf[0][6]),  32'd15);
        check("inv_x9",  32'(fbuf[2][9]),  32'd14);
        check("inv_x53", 32'(fbuf[0][53]), 32'd0);
        check("inv_x54", 32'(fbuf[0][54]), 32'd0);

        // Checkerboard.
        bus.mode = 2'd1;
        launch();
        run_until_idle(1'b0, 1'b0, 2 * FRAME);
        check("chk_y0_x3", 32'(fbuf[0][3]), 32'd0);
        check("chk_y0_x4", 32'(fbuf[0][4]), 32'd15);
        check("chk_y4_x0", 32'(fbuf[4][0]), 32'd15);
        check("chk_y4_x4", 32'(fbuf[4][4]), 32'd0);

        // Solid colour with mid-frame mode/level/start noise.
        bus.mode  = 2'd2;
        bus.level = DW'(8);
        launch();
        run_until_idle(1'b1, 1'b0, 2 * FRAME);
        bad = 0;
        for (int y = 0; y < V_A; y++)
            for (int x = 0; x < H_A; x++) if (fbuf[y][x] !== DW'(8)) bad++;
        check("solid_bad_px", 32'(bad), 32'd0);

        // Continuous: two frames, cont dropped mid-second, start pulse mid-first.
        bus.mode = 2'($urandom);
        bus.cont = 1'b1;
        launch();
        vs_rises = 1;
        busy_cyc = 3 - 1;
        vs_prev  = bus.v_sync;
        n        = 0;
        while (bus.busy && n < 4 * FRAME) begin
            if (n == 50) bus.start = 1'b1;
            if (n == 60) bus.start = 1'b0;
            if (vs_rises == 2 && m_t > FRAME / 2) bus.cont = 1'b0;
            step();
            n++;
            if (bus.busy) busy_cyc++;
            if (bus.v_sync && !vs_prev) vs_rises++;
            vs_prev = bus.v_sync;
        end
        check("cont_idle", 32'(bus.busy), 32'd0);
        check("cont_vsync_frames", 32'(vs_rises), 32'd2);
        check("cont_busy_cycles", 32'(busy_cyc), 32'(2 * FRAME));

        // Reset in the middle of an active line.
        bus.mode = 2'd0;
        launch();
        n = 0;
        while (!(m_busy && m_t / L == 1 && m_t % L >= H_B + 5) && n < 2 * FRAME) begin
            step();
            n++;
        end
        check("reached_mid_active", 32'(bus.d_en), 32'd1);
        do_reset();
        repeat (5) step();

        // Randomised frames.
        for (int i = 0; i < 8; i++) begin
            bus.mode  = 2'($urandom);
            bus.level = DW'($urandom);
            bus.cont  = 1'($urandom);
            launch();
            run_until_idle(1'b1, 1'b1, 5 * FRAME);
            bus.cont = 1'b0;
            repeat (4) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
